// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer:
// stage indices, per-cause control codes and FSM state types.
package pipeline_ctrl_pkg;

   localparam int STG_PC   = 0;
   localparam int STG_IFID = 1;
   localparam int STG_IDEX = 2;
   localparam int STG_EXMM = 3;
   localparam int STG_WB   = 4;

   localparam logic [4:0] BIT_PC   = 5'(1 << STG_PC);
   localparam logic [4:0] BIT_IFID = 5'(1 << STG_IFID);
   localparam logic [4:0] BIT_IDEX = 5'(1 << STG_IDEX);
   localparam logic [4:0] BIT_EXMM = 5'(1 << STG_EXMM);
   localparam logic [4:0] BIT_WB   = 5'(1 << STG_WB);

   // Each cause holds everything upstream of its bubble point
   localparam logic [4:0] STALL_MEM =
      BIT_PC | BIT_IFID | BIT_IDEX | BIT_EXMM;
   localparam logic [4:0] FLUSH_MEM = BIT_WB;
   localparam logic [4:0] STALL_DIV = BIT_PC | BIT_IFID | BIT_IDEX;
   localparam logic [4:0] FLUSH_DIV = BIT_EXMM;
   localparam logic [4:0] STALL_LU  = BIT_PC | BIT_IFID;
   localparam logic [4:0] FLUSH_LU  = BIT_IDEX;
   localparam logic [4:0] FLUSH_BR  = BIT_IFID;

   typedef enum logic {M_IDLE, M_WAIT} mem_state_t;
   typedef enum logic {D_IDLE, D_RUN} div_state_t;

   function automatic logic reg_hit(
      input logic       use_r,
      input logic [4:0] src,
      input logic [4:0] dst
   );
      return use_r && (src == dst);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_mem_wait_fsm.sv
// Data-memory req/ack sequencer for the MEM stage with a
// bounded wait; a timeout forces completion and pulses timeout.
module pipeline_ctrl_mem_wait_fsm
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_req,
   input  logic mem_ack,
   output logic dmem_req,
   output logic mem_stall,
   output logic timeout
);

   mem_state_t state;
   logic [7:0] to_cnt;
   logic       at_limit;
   logic       req_c;
   logic       stall_c;

   assign at_limit = (to_cnt == 8'(MEM_TIMEOUT));

   always_comb begin
      req_c   = 1'b0;
      stall_c = 1'b0;
      timeout = 1'b0;
      unique case (state)
         M_IDLE: begin
            req_c   = mem_req;
            stall_c = mem_req & ~mem_ack;
         end
         M_WAIT: begin
            req_c   = 1'b1;
            stall_c = ~(mem_ack | at_limit);
            timeout = rst & ~mem_ack & at_limit;
         end
      endcase
   end

   // Held in reset, nothing may reach memory or the pipeline
   assign dmem_req  = rst & req_c;
   assign mem_stall = rst & stall_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= M_IDLE;
         to_cnt <= 8'd0;
      end else begin
         unique case (state)
            M_IDLE: begin
               if (mem_req && !mem_ack) begin
                  state  <= M_WAIT;
                  to_cnt <= 8'd1;
               end
            end
            M_WAIT: begin
               if (!stall_c) begin
                  state  <= M_IDLE;
                  to_cnt <= 8'd0;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: mem wait,
// mult/div occupancy of EX, load-use hazard and branch squash.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES  = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_is_load,
   input  logic [4:0] ex_waddr,
   input  logic       ex_div_start,
   input  logic       mem_req,
   input  logic       mem_ack,
   input  logic       branch_taken,
   input  logic       err_clr,
   output logic       dmem_req,
   output logic [4:0] stall,
   output logic [4:0] flush,
   output logic       div_busy,
   output logic       mem_timeout_err
);

   localparam int DW = $clog2(DIV_CYCLES + 1);

   logic          mem_stall;
   logic          timeout;
   logic          div_stall;
   logic          load_use;
   div_state_t    div_state;
   logic [DW-1:0] div_cnt;
   logic          c_mem;
   logic          c_div;
   logic          c_lu;
   logic          c_br;

   pipeline_ctrl_mem_wait_fsm #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (mem_req),
      .mem_ack  (mem_ack),
      .dmem_req (dmem_req),
      .mem_stall(mem_stall),
      .timeout  (timeout)
   );

   assign load_use = ex_is_load && (ex_waddr != 5'd0) &&
      (reg_hit(id_use_rs, id_rs, ex_waddr) ||
       reg_hit(id_use_rt, id_rt, ex_waddr));

   always_comb begin
      div_stall = 1'b0;
      unique case (div_state)
         D_IDLE: div_stall = ex_div_start & ~mem_stall;
         D_RUN:  div_stall = (div_cnt != '0);
      endcase
   end

   assign c_mem = mem_stall;
   assign c_div = div_stall & ~mem_stall;
   assign c_lu  = load_use & ~mem_stall & ~div_stall;
   assign c_br  = branch_taken &
      ~(mem_stall | div_stall | load_use);

   always_comb begin
      stall = 5'd0;
      flush = 5'd0;
      if (rst) begin
         unique case (1'b1)
            c_mem: begin
               stall = STALL_MEM;
               flush = FLUSH_MEM;
            end
            c_div: begin
               stall = STALL_DIV;
               flush = FLUSH_DIV;
            end
            c_lu: begin
               stall = STALL_LU;
               flush = FLUSH_LU;
            end
            c_br:    flush = FLUSH_BR;
            default: ;
         endcase
      end
   end

   // Whole divider is frozen while MEM holds EX in place
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_state <= D_IDLE;
         div_cnt   <= '0;
         div_busy  <= 1'b0;
      end else if (!mem_stall) begin
         unique case (div_state)
            D_IDLE: begin
               if (ex_div_start) begin
                  div_state <= D_RUN;
                  div_cnt   <= DW'(DIV_CYCLES - 1);
                  div_busy  <= 1'b1;
               end
            end
            D_RUN: begin
               if (div_cnt == '0) begin
                  div_state <= D_IDLE;
                  div_busy  <= 1'b0;
               end else begin
                  div_cnt <= div_cnt - DW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_timeout_err <= 1'b0;
      end else if (timeout) begin
         mem_timeout_err <= 1'b1;
      end else if (err_clr) begin
         mem_timeout_err <= 1'b0;
      end
   end

endmodule
